// File: rtl/fir_pkg.sv
// Shared types and sizes for the FIR sequencer and its neighbours.
// ADDR_W/TAP_W match the Ile_probek/Ile_wsp fields in ctrl_registers.
package fir_pkg;

    localparam int ADDR_W     = 14;
    localparam int TAP_W      = 6;
    localparam int RD_LAT_MAX = 4;
    localparam int DRAIN_W    = $clog2(RD_LAT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        WRITE,
        FINISHED
    } fir_seq_state_t;

endpackage

// File: rtl/fir_strobe_delay.sv
// Delays {rd_en, first_tap} by the memory read latency so that
// acc_en/acc_clr line up with the data returned by the memories.
module fir_strobe_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk_b,
    input  logic rst_n,
    input  logic rd_en,
    input  logic first_tap,
    output logic acc_en,
    output logic acc_clr
);

    logic [1:0] sr [DEPTH];

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= {rd_en, first_tap};
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign {acc_en, acc_clr} = sr[DEPTH-1];

endmodule

// File: rtl/fir_sequencer.sv
// Walks all output samples and taps of the FIR, driving memory reads,
// accumulator strobes and result writes after a Start rising edge.
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = fir_pkg::ADDR_W,
    parameter int TAP_W  = fir_pkg::TAP_W
) (
    input  logic              clk_b,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [TAP_W-1:0]  Ile_wsp,
    input  logic [ADDR_W-1:0] Ile_probek,
    output logic              Pracuje,
    output logic              DONE,
    output logic              rd_en,
    output logic [ADDR_W-1:0] probka_addr,
    output logic [TAP_W-1:0]  wsp_addr,
    output logic              probka_zero,
    output logic              acc_clr,
    output logic              acc_en,
    output logic [ADDR_W-1:0] wynik_addr,
    output logic              wynik_wr
);

    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT - 1);

    fir_seq_state_t      state;
    logic                start_q;
    logic                trigger;
    logic                first_tap;
    logic [TAP_W-1:0]    w_q;
    logic [ADDR_W-1:0]   n_q;
    logic [ADDR_W-1:0]   n_cnt;
    logic [TAP_W-1:0]    k_cnt;
    logic [DRAIN_W-1:0]  dcnt;

    assign trigger = Start & ~start_q;

    // {zero, addr}: n-k in ADDR_W+1 bits, clamped to 0 when negative
    function automatic logic [ADDR_W:0] tap_addr(
        input logic [ADDR_W-1:0] n,
        input logic [TAP_W-1:0]  k
    );
        logic [ADDR_W:0] d;
        d = {1'b0, n} - {{(ADDR_W+1-TAP_W){1'b0}}, k};
        if (d[ADDR_W]) return {1'b1, {ADDR_W{1'b0}}};
        return {1'b0, d[ADDR_W-1:0]};
    endfunction

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            first_tap   <= 1'b0;
            w_q         <= '0;
            n_q         <= '0;
            n_cnt       <= '0;
            k_cnt       <= '0;
            dcnt        <= '0;
            Pracuje     <= 1'b0;
            DONE        <= 1'b0;
            rd_en       <= 1'b0;
            probka_addr <= '0;
            wsp_addr    <= '0;
            probka_zero <= 1'b0;
            wynik_addr  <= '0;
            wynik_wr    <= 1'b0;
        end else begin
            start_q <= Start;
            unique case (state)
                IDLE, FINISHED: begin
                    if (trigger) begin
                        w_q   <= Ile_wsp;
                        n_q   <= Ile_probek;
                        n_cnt <= '0;
                        k_cnt <= '0;
                        DONE  <= 1'b0;
                        if (Ile_wsp == '0 || Ile_probek == '0) begin
                            state <= FINISHED;
                        end else begin
                            state       <= MAC;
                            Pracuje     <= 1'b1;
                            rd_en       <= 1'b1;
                            first_tap   <= 1'b1;
                            probka_addr <= '0;
                            wsp_addr    <= '0;
                            probka_zero <= 1'b0;
                        end
                    end else if (state == FINISHED) begin
                        DONE <= 1'b1;
                    end
                end
                MAC: begin
                    first_tap <= 1'b0;
                    if (k_cnt == w_q - TAP_W'(1)) begin
                        state       <= DRAIN;
                        rd_en       <= 1'b0;
                        probka_addr <= '0;
                        wsp_addr    <= '0;
                        probka_zero <= 1'b0;
                        dcnt        <= DRAIN_LAST;
                    end else begin
                        k_cnt    <= k_cnt + TAP_W'(1);
                        wsp_addr <= k_cnt + TAP_W'(1);
                        {probka_zero, probka_addr} <=
                            tap_addr(n_cnt, k_cnt + TAP_W'(1));
                    end
                end
                DRAIN: begin
                    if (dcnt == '0) begin
                        state      <= WRITE;
                        wynik_wr   <= 1'b1;
                        wynik_addr <= n_cnt;
                    end else begin
                        dcnt <= dcnt - DRAIN_W'(1);
                    end
                end
                WRITE: begin
                    wynik_wr   <= 1'b0;
                    wynik_addr <= '0;
                    if (n_cnt == n_q - ADDR_W'(1)) begin
                        state   <= FINISHED;
                        Pracuje <= 1'b0;
                    end else begin
                        state       <= MAC;
                        n_cnt       <= n_cnt + ADDR_W'(1);
                        k_cnt       <= '0;
                        rd_en       <= 1'b1;
                        first_tap   <= 1'b1;
                        probka_addr <= n_cnt + ADDR_W'(1);
                        wsp_addr    <= '0;
                        probka_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fir_strobe_delay #(
        .DEPTH(RD_LAT)
    ) u_delay (
        .clk_b    (clk_b),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .first_tap(first_tap),
        .acc_en   (acc_en),
        .acc_clr  (acc_clr)
    );

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: one DUT with RD_LAT=1, one with RD_LAT=3.
module tb_fir_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        s1_start = 1'b0;
    logic [5:0]  s1_wsp = '0;
    logic [13:0] s1_probek = '0;
    logic        o1_busy, o1_done, o1_rd, o1_pz, o1_clr, o1_acc, o1_wr;
    logic [13:0] o1_pa, o1_wa;
    logic [5:0]  o1_wsa;

    logic        s3_start = 1'b0;
    logic [5:0]  s3_wsp = '0;
    logic [13:0] s3_probek = '0;
    logic        o3_busy, o3_done, o3_rd, o3_pz, o3_clr, o3_acc, o3_wr;
    logic [13:0] o3_pa, o3_wa;
    logic [5:0]  o3_wsa;

    fir_sequencer #(.RD_LAT(1)) d1 (
        .clk_b(clk), .rst_n(rst_n), .Start(s1_start),
        .Ile_wsp(s1_wsp), .Ile_probek(s1_probek),
        .Pracuje(o1_busy), .DONE(o1_done), .rd_en(o1_rd),
        .probka_addr(o1_pa), .wsp_addr(o1_wsa), .probka_zero(o1_pz),
        .acc_clr(o1_clr), .acc_en(o1_acc),
        .wynik_addr(o1_wa), .wynik_wr(o1_wr)
    );

    fir_sequencer #(.RD_LAT(3)) d3 (
        .clk_b(clk), .rst_n(rst_n), .Start(s3_start),
        .Ile_wsp(s3_wsp), .Ile_probek(s3_probek),
        .Pracuje(o3_busy), .DONE(o3_done), .rd_en(o3_rd),
        .probka_addr(o3_pa), .wsp_addr(o3_wsa), .probka_zero(o3_pz),
        .acc_clr(o3_clr), .acc_en(o3_acc),
        .wynik_addr(o3_wa), .wynik_wr(o3_wr)
    );

    // per-step capture, index = cycles since the accept edge + 1
    logic        c_rd [64];
    logic        c_acc [64];
    logic        c_clr [64];
    logic        c_wr [64];
    logic        c_pz [64];
    logic        c_busy [64];
    logic        c_done [64];
    logic [13:0] c_pa [64];
    logic [13:0] c_wa [64];
    logic [5:0]  c_wsa [64];

    function automatic logic [50:0] outs1();
        return {o1_busy, o1_done, o1_rd, o1_pa, o1_wsa, o1_pz,
                o1_clr, o1_acc, o1_wa, o1_wr};
    endfunction

    function automatic logic [50:0] outs3();
        return {o3_busy, o3_done, o3_rd, o3_pa, o3_wsa, o3_pz,
                o3_clr, o3_acc, o3_wa, o3_wr};
    endfunction

    task automatic cap(input bit sel3, input int s);
        if (sel3) begin
            c_rd[s] = o3_rd; c_acc[s] = o3_acc; c_clr[s] = o3_clr;
            c_wr[s] = o3_wr; c_pz[s] = o3_pz; c_busy[s] = o3_busy;
            c_done[s] = o3_done; c_pa[s] = o3_pa; c_wa[s] = o3_wa;
            c_wsa[s] = o3_wsa;
        end else begin
            c_rd[s] = o1_rd; c_acc[s] = o1_acc; c_clr[s] = o1_clr;
            c_wr[s] = o1_wr; c_pz[s] = o1_pz; c_busy[s] = o1_busy;
            c_done[s] = o1_done; c_pa[s] = o1_pa; c_wa[s] = o1_wa;
            c_wsa[s] = o1_wsa;
        end
    endtask

    // Pulse Start one cycle and record `steps` cycles of outputs.
    task automatic run(input bit sel3, input int w, input int n,
                       input int steps);
        for (int s = 0; s < 64; s++) begin
            c_rd[s] = 0; c_acc[s] = 0; c_clr[s] = 0; c_wr[s] = 0;
            c_pz[s] = 0; c_busy[s] = 0; c_done[s] = 0;
            c_pa[s] = '0; c_wa[s] = '0; c_wsa[s] = '0;
        end
        if (sel3) begin
            s3_wsp = 6'(w); s3_probek = 14'(n); s3_start = 1'b1;
        end else begin
            s1_wsp = 6'(w); s1_probek = 14'(n); s1_start = 1'b1;
        end
        for (int s = 1; s <= steps; s++) begin
            @(posedge clk); #1;
            if (s == 1) begin
                s1_start = 1'b0;
                s3_start = 1'b0;
            end
            cap(sel3, s);
        end
    endtask

    function automatic int first_done(input int steps);
        for (int s = 1; s <= steps; s++) if (c_done[s]) return s;
        return -1;
    endfunction

    task automatic test_reset();
        s1_start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (outs1() !== '0) begin
            failures++;
            $display("FAIL reset_d1 got=%h want=0", outs1());
        end
        checks++;
        if (outs3() !== '0) begin
            failures++;
            $display("FAIL reset_d3 got=%h want=0", outs3());
        end
        s1_start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int nrd, nacc, nclr, nwr, lag, k;
        int ws [4];
        logic [13:0] wa [4];
        logic [13:0] epa [3];
        logic [5:0]  ewk [3];
        logic        epz [3];
        run(0, 3, 4, 30);
        nrd = 0; nacc = 0; nclr = 0; nwr = 0; lag = 0; k = 0;
        for (int s = 1; s <= 30; s++) begin
            if (c_rd[s]) nrd++;
            if (c_acc[s]) nacc++;
            if (c_acc[s] && c_clr[s]) nclr++;
            if (c_acc[s] !== ((s > 1) ? c_rd[s-1] : 1'b0)) lag++;
            if (c_wr[s] && nwr < 4) begin
                ws[nwr] = s; wa[nwr] = c_wa[s]; nwr++;
            end
            if (c_rd[s]) begin
                if (k >= 3 && k < 6) begin
                    epa[k-3] = c_pa[s]; ewk[k-3] = c_wsa[s];
                    epz[k-3] = c_pz[s];
                end
                k++;
            end
        end
        checks++;
        if (c_busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got=%b want=1", c_busy[1]);
        end
        checks++;
        if (nrd != 12) begin
            failures++;
            $display("FAIL basic_rd_count got=%0d want=12", nrd);
        end
        checks++;
        if (nacc != 12) begin
            failures++;
            $display("FAIL basic_acc_count got=%0d want=12", nacc);
        end
        checks++;
        if (nclr != 4) begin
            failures++;
            $display("FAIL basic_clr_count got=%0d want=4", nclr);
        end
        checks++;
        if (lag != 0) begin
            failures++;
            $display("FAIL basic_acc_lag got=%0d want=0 errors", lag);
        end
        checks++;
        if (nwr != 4) begin
            failures++;
            $display("FAIL basic_wr_count got=%0d want=4", nwr);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ws[i] != 5 + 5 * i || wa[i] !== 14'(i)) begin
                    failures++;
                    $display("FAIL basic_wr%0d got=step%0d,addr%0d want=step%0d,addr%0d",
                             i, ws[i], wa[i], 5 + 5 * i, i);
                end
            end
        end
        checks++;
        if (first_done(30) != 22) begin
            failures++;
            $display("FAIL basic_done_step got=%0d want=22", first_done(30));
        end
        begin
            logic [13:0] xpa [3];
            logic        xpz [3];
            xpa[0] = 14'd1; xpa[1] = 14'd0; xpa[2] = 14'd0;
            xpz[0] = 1'b0;  xpz[1] = 1'b0;  xpz[2] = 1'b1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (epa[i] !== xpa[i] || ewk[i] !== 6'(i) || epz[i] !== xpz[i]) begin
                    failures++;
                    $display("FAIL n1_tap%0d got=(%0d,%0d,%b) want=(%0d,%0d,%b)",
                             i, epa[i], ewk[i], epz[i], xpa[i], i, xpz[i]);
                end
            end
        end
    endtask

    task automatic test_zero_taps();
        int bad;
        run(0, 0, 10, 12);
        checks++;
        if (c_done[1] !== 1'b0 || c_done[2] !== 1'b1) begin
            failures++;
            $display("FAIL w0_done got=%b%b want=01", c_done[1], c_done[2]);
        end
        bad = 0;
        for (int s = 1; s <= 12; s++)
            if (c_rd[s] || c_wr[s] || c_acc[s] || c_busy[s]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL w0_traffic got=%0d want=0 active cycles", bad);
        end
    endtask

    task automatic test_held_start();
        int dstep;
        s1_wsp = 6'd2; s1_probek = 14'd2; s1_start = 1'b1;
        dstep = -1;
        for (int s = 1; s <= 16; s++) begin
            @(posedge clk); #1;
            if (s == 3) s1_start = 1'b0;
            if (s == 5) s1_start = 1'b1;
            if (o1_done && dstep < 0) dstep = s;
        end
        checks++;
        if (dstep != 10) begin
            failures++;
            $display("FAIL held_done_step got=%0d want=10", dstep);
        end
        checks++;
        if (o1_done !== 1'b1 || o1_busy !== 1'b0) begin
            failures++;
            $display("FAIL held_sticky got=done%b,busy%b want=done1,busy0",
                     o1_done, o1_busy);
        end
        s1_start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o1_done !== 1'b1) begin
            failures++;
            $display("FAIL held_fall got=%b want=1", o1_done);
        end
        s1_start = 1'b1;
        @(posedge clk); #1;
        s1_start = 1'b0;
        checks++;
        if (o1_done !== 1'b0 || o1_busy !== 1'b1) begin
            failures++;
            $display("FAIL held_restart got=done%b,busy%b want=done0,busy1",
                     o1_done, o1_busy);
        end
        dstep = -1;
        for (int s = 2; s <= 20; s++) begin
            @(posedge clk); #1;
            if (o1_done && dstep < 0) dstep = s;
        end
        checks++;
        if (dstep != 10) begin
            failures++;
            $display("FAIL held_rerun got=%0d want=10", dstep);
        end
    endtask

    task automatic test_reset_mid();
        int bad, nwr;
        s1_wsp = 6'd3; s1_probek = 14'd4; s1_start = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            @(posedge clk); #1;
            if (s == 1) s1_start = 1'b0;
        end
        checks++;
        if (o1_rd !== 1'b1 || o1_pa !== 14'd1 || o1_wsa !== 6'd1) begin
            failures++;
            $display("FAIL mid_pre got=rd%b,pa%0d,k%0d want=rd1,pa1,k1",
                     o1_rd, o1_pa, o1_wsa);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs1() !== '0) begin
            failures++;
            $display("FAIL mid_async got=%h want=0", outs1());
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int s = 0; s < 30; s++) begin
            @(posedge clk); #1;
            if (o1_wr || o1_done || o1_rd || o1_acc || o1_busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mid_quiet got=%0d want=0 active cycles", bad);
        end
        run(0, 3, 4, 26);
        nwr = 0;
        for (int s = 1; s <= 26; s++) if (c_wr[s]) nwr++;
        checks++;
        if (nwr != 4 || first_done(26) != 22) begin
            failures++;
            $display("FAIL mid_rerun got=wr%0d,done%0d want=wr4,done22",
                     nwr, first_done(26));
        end
    endtask

    task automatic test_lat3();
        int nrd, nacc, lag, nwr, na;
        int ws [2];
        int as [4];
        run(1, 2, 2, 20);
        nrd = 0; nacc = 0; lag = 0; nwr = 0; na = 0;
        for (int s = 1; s <= 20; s++) begin
            if (c_rd[s]) nrd++;
            if (c_acc[s]) begin
                nacc++;
                if (na < 4) begin as[na] = s; na++; end
            end
            if (c_acc[s] !== ((s > 3) ? c_rd[s-3] : 1'b0)) lag++;
            if (c_wr[s] && nwr < 2) begin ws[nwr] = s; nwr++; end
        end
        checks++;
        if (nrd != 4 || nacc != 4 || lag != 0) begin
            failures++;
            $display("FAIL lat3_strobes got=rd%0d,acc%0d,lagerr%0d want=rd4,acc4,lagerr0",
                     nrd, nacc, lag);
        end
        checks++;
        if (nwr != 2 || na != 4) begin
            failures++;
            $display("FAIL lat3_wr_count got=wr%0d,acc%0d want=wr2,acc4", nwr, na);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ws[i] != 6 + 6 * i || ws[i] != as[2*i+1] + 1) begin
                    failures++;
                    $display("FAIL lat3_wr%0d got=step%0d,lastacc%0d want=step%0d",
                             i, ws[i], as[2*i+1], 6 + 6 * i);
                end
            end
        end
        checks++;
        if (first_done(20) != 14) begin
            failures++;
            $display("FAIL lat3_done_step got=%0d want=14", first_done(20));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_taps();
        test_held_start();
        test_reset_mid();
        test_lat3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
